// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter: two-requester round-robin front end for a cache engine.
// One access is in flight at a time: IDLE -> ISSUE (1 cycle) -> WAIT (ENGINE_LAT-1
// cycles) -> IDLE with a completion pulse. Zero-address accesses are accepted but
// dropped (never issued) and answered with a drop-flagged pulse on the next cycle.
// Optional feature macro: CACHE_ARB_STATS_EN enables the per-requester grant counters;
// without it grant_cnt0/grant_cnt1 are tied to zero.
module cache_req_arbiter #(
   parameter int ENGINE_LAT = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic [47:0] req0_addr,
   input  logic [7:0]  req0_op,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [47:0] req1_addr,
   input  logic [7:0]  req1_op,
   output logic        req1_ready,
   input  logic        cfg_write_policy,
   output logic [47:0] cache_addr,
   output logic [7:0]  cache_op,
   output logic        write_policy,
   output logic        busy,
   output logic        resp_valid,
   output logic        resp_id,
   output logic        resp_drop,
   output logic [15:0] drop_cnt,
   output logic [17:0] grant_cnt0,
   output logic [17:0] grant_cnt1
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   // WAIT lasts ENGINE_LAT-1 cycles: the counter starts at ENGINE_LAT-2 and exits at 0.
   localparam logic [3:0] WAIT_LOAD = 4'(ENGINE_LAT - 2);

   state_t      r_state;
   logic [3:0]  r_wait_cnt;
   logic        r_last_grant;
   logic        r_id;
   logic [47:0] r_cache_addr;
   logic [7:0]  r_cache_op;
   logic        r_write_policy;
   logic        r_resp_valid;
   logic        r_resp_id;
   logic        r_resp_drop;
   logic [15:0] r_drop_cnt;

   logic        w_win;
   logic        w_can_accept;
   logic        w_accept;
   logic [47:0] w_sel_addr;
   logic [7:0]  w_sel_op;

   // Round-robin winner: the requester not granted last wins a tie, a lone requester always wins.
   always_comb begin
      w_win = 1'b0;
      if (req0_valid && req1_valid) begin
         w_win = ~r_last_grant;
      end else if (req1_valid) begin
         w_win = 1'b1;
      end else begin
         w_win = 1'b0;
      end
   end

   // Accepts only in IDLE, never during the drop-response cycle, never while in reset.
   assign w_can_accept = reset && (r_state == S_IDLE) && !r_resp_drop;
   assign w_accept     = w_can_accept && (req0_valid || req1_valid);
   assign req0_ready   = w_accept && !w_win;
   assign req1_ready   = w_accept && w_win;
   assign w_sel_addr   = w_win ? req1_addr : req0_addr;
   assign w_sel_op     = w_win ? req1_op   : req0_op;

   // Main FSM with registered engine-side and response outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state        <= S_IDLE;
         r_wait_cnt     <= 4'd0;
         r_last_grant   <= 1'b1;
         r_id           <= 1'b0;
         r_cache_addr   <= 48'd0;
         r_cache_op     <= 8'd0;
         r_write_policy <= 1'b0;
         r_resp_valid   <= 1'b0;
         r_resp_id      <= 1'b0;
         r_resp_drop    <= 1'b0;
         r_drop_cnt     <= 16'd0;
      end else begin
         r_resp_valid <= 1'b0;
         r_resp_drop  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_last_grant <= w_win;
                  r_id         <= w_win;
                  if (w_sel_addr == 48'd0) begin
                     // Dropped: stay IDLE, answer next cycle with the drop flag.
                     r_resp_valid <= 1'b1;
                     r_resp_drop  <= 1'b1;
                     r_resp_id    <= w_win;
                     if (r_drop_cnt != 16'hFFFF) begin
                        r_drop_cnt <= r_drop_cnt + 16'd1;
                     end
                  end else begin
                     r_cache_addr <= w_sel_addr;
                     r_cache_op   <= w_sel_op;
                     r_state      <= S_ISSUE;
                  end
               end else begin
                  // Policy only changes between accesses.
                  r_write_policy <= cfg_write_policy;
               end
            end
            S_ISSUE: begin
               r_cache_addr <= 48'd0;
               r_wait_cnt   <= WAIT_LOAD;
               r_state      <= S_WAIT;
            end
            S_WAIT: begin
               if (r_wait_cnt == 4'd0) begin
                  r_state      <= S_IDLE;
                  r_resp_valid <= 1'b1;
                  r_resp_id    <= r_id;
               end else begin
                  r_wait_cnt <= r_wait_cnt - 4'd1;
               end
            end
            default: begin
               r_state      <= S_IDLE;
               r_cache_addr <= 48'd0;
            end
         endcase
      end
   end

   assign cache_addr   = r_cache_addr;
   assign cache_op     = r_cache_op;
   assign write_policy = r_write_policy;
   assign busy         = (r_state != S_IDLE);
   assign resp_valid   = r_resp_valid;
   assign resp_id      = r_resp_id;
   assign resp_drop    = r_resp_drop;
   assign drop_cnt     = r_drop_cnt;

`ifdef CACHE_ARB_STATS_EN
   logic [17:0] r_grant_cnt0;
   logic [17:0] r_grant_cnt1;

   // Per-requester grant counters, counting drops too, wrapping naturally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_grant_cnt0 <= 18'd0;
         r_grant_cnt1 <= 18'd0;
      end else if (w_accept) begin
         if (w_win) begin
            r_grant_cnt1 <= r_grant_cnt1 + 18'd1;
         end else begin
            r_grant_cnt0 <= r_grant_cnt0 + 18'd1;
         end
      end
   end

   assign grant_cnt0 = r_grant_cnt0;
   assign grant_cnt1 = r_grant_cnt1;
`else
   assign grant_cnt0 = 18'd0;
   assign grant_cnt1 = 18'd0;
`endif

endmodule
